// File: rtl/uart_pkg.sv
// uart_pkg: register map, CTRL bit positions and the FSM state
// type shared by the transmitter and the receiver.
package uart_pkg;

    localparam logic [3:0] UART_CTRL = 4'h0;
    localparam logic [3:0] UART_TX   = 4'h4;
    localparam logic [3:0] UART_BAUD = 4'h8;
    localparam logic [3:0] UART_RX   = 4'hC;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_BUSY  = 2;
    localparam int CTRL_RX_VALID = 3;
    localparam int CTRL_RX_FERR  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop input synchronizer, mid-bit
// sampling and sticky valid / framing-error flags.
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_en,
    input  logic [15:0] bit_per,
    input  logic        rx_in,
    input  logic        clr_valid,
    input  logic        clr_ferr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_ferr
);

    logic        s1, s2, s_prev;
    uart_state_t state;
    logic [15:0] cnt, per;
    logic [2:0]  bitn;
    logic [7:0]  shift;
    logic        bit_end, half_end;

    assign bit_end  = cnt >= per - 16'd1;
    assign half_end = cnt >= (per >> 1) - 16'd1;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s_prev   <= 1'b1;
            state    <= ST_IDLE;
            cnt      <= '0;
            per      <= 16'd2;
            bitn     <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            s1     <= rx_in;
            s2     <= s1;
            s_prev <= s2;
            if (clr_valid) rx_valid <= 1'b0;
            if (clr_ferr)  rx_ferr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_en && s_prev && !s2) begin
                        state <= ST_START;
                        cnt   <= '0;
                        per   <= bit_per;
                    end
                end
                // first sample lands mid start bit; later ones one period apart
                ST_START: begin
                    if (half_end) begin
                        cnt  <= '0;
                        per  <= bit_per;
                        bitn <= '0;
                        state <= s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        per   <= bit_per;
                        shift <= {s2, shift[7:1]};
                        if (bitn == 3'd7) state <= ST_STOP;
                        else bitn <= bitn + 3'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (s2) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_top_si.sv
// uart_top_si: register-mapped 8N1 UART (TX, baud divider, regs).
// Receiver is compiled in only when UART_RX_EN is defined.
module uart_top_si
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        uart_tx,
    input  logic        uart_rx
);

    logic        tx_en, rx_en, tx_busy;
    logic        rx_valid, rx_ferr;
    logic [7:0]  tx_data, tx_shift, rx_data;
    logic [15:0] baud, baud_eff, tx_per, tx_cnt;
    logic [2:0]  tx_bit;
    uart_state_t tx_state;
    logic        ctrl_wr, tx_wr, baud_wr, tx_go, tx_end;
    logic        unused_wd;

    assign ctrl_wr  = we && (addr == UART_CTRL);
    assign tx_wr    = we && (addr == UART_TX);
    assign baud_wr  = we && (addr == UART_BAUD);
    assign baud_eff = (baud < 16'd2) ? 16'd2 : baud;
    assign tx_busy  = tx_state != ST_IDLE;
    assign tx_go    = tx_wr && tx_en && !tx_busy;
    assign tx_end   = tx_cnt >= tx_per - 16'd1;
    assign unused_wd = ^wd[31:16];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tx_en   <= 1'b0;
            baud    <= '0;
            tx_data <= '0;
        end else begin
            if (ctrl_wr) tx_en <= wd[CTRL_TX_EN];
            if (baud_wr) baud <= wd[15:0];
            if (tx_wr && !tx_busy) tx_data <= wd[7:0];
        end
    end

    // bit period is re-latched at every bit boundary
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tx_state <= ST_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_per   <= 16'd2;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_go) begin
                        tx_state <= ST_START;
                        uart_tx  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_per   <= baud_eff;
                        tx_shift <= wd[7:0];
                    end
                end
                ST_START: begin
                    if (tx_end) begin
                        tx_state <= ST_DATA;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                        tx_per   <= baud_eff;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_end) begin
                        tx_cnt <= '0;
                        tx_per <= baud_eff;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_end) begin
                        tx_state <= ST_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) rx_en <= 1'b0;
        else if (ctrl_wr) rx_en <= wd[CTRL_RX_EN];
    end

    uart_rx u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .rx_en     (rx_en),
        .bit_per   (baud_eff),
        .rx_in     (uart_rx),
        .clr_valid (ctrl_wr && !wd[CTRL_RX_VALID]),
        .clr_ferr  (ctrl_wr && !wd[CTRL_RX_FERR]),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ferr   (rx_ferr)
    );
`else
    logic unused_rx;
    assign unused_rx = uart_rx;
    assign rx_en     = 1'b0;
    assign rx_valid  = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_data   = '0;
`endif

    always_comb begin
        rd = '0;
        case (addr)
            UART_CTRL: rd[4:0]  = {rx_ferr, rx_valid, tx_busy, rx_en, tx_en};
            UART_TX:   rd[7:0]  = tx_data;
            UART_BAUD: rd[15:0] = baud;
            UART_RX:   rd[7:0]  = rx_data;
            default:   rd = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_top_si.sv
// tb_uart_top_si: randomized bench; serial TX frames are decoded by a
// monitor and scored against a queue filled by the stimulus.
module tb_uart_top_si;

    localparam logic [3:0] A_CTRL = 4'h0;
    localparam logic [3:0] A_TX   = 4'h4;
    localparam logic [3:0] A_BAUD = 4'h8;
    localparam logic [3:0] A_RX   = 4'hC;

    logic        clk = 1'b0;
    logic        rstn, we, uart_rx, uart_tx;
    logic [3:0]  addr;
    logic [31:0] wd, rd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] b;
        int         per;
    } txe_t;
    txe_t tx_q[$];
    int   mon_per = 16;

    logic       m_txen, m_rxen, m_valid, m_ferr;
    logic [7:0] m_data;

    uart_top_si dut (
        .clk     (clk),
        .rstn    (rstn),
        .addr    (addr),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff(input int b);
        return (b < 2) ? 2 : b;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rdr(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic ctrl_w(input logic [31:0] d);
        wr(A_CTRL, d);
        m_txen = d[0];
`ifdef UART_RX_EN
        m_rxen = d[1];
`endif
        m_valid = m_valid & d[3];
        m_ferr  = m_ferr & d[4];
    endtask

    task automatic set_baud(input int b);
        wr(A_BAUD, b);
        mon_per = eff(b);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            rdr(A_CTRL, v);
            n++;
        end while (v[2] && n < 30000);
        if (v[2]) check("idle_timeout", {31'd0, v[2]}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        tx_q.push_back('{b, mon_per});
        wr(A_TX, {24'd0, b});
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int p);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (p) @(negedge clk);
        end
        uart_rx = stop;
        repeat (p) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * p) @(negedge clk);
    endtask

    task automatic rx_check(input string tag);
        logic [31:0] v;
        rdr(A_CTRL, v);
        check({tag, "_ctrl"}, v, {27'd0, m_ferr, m_valid, 1'b0, m_rxen, m_txen});
        rdr(A_RX, v);
        check({tag, "_data"}, v, {24'd0, m_data});
    endtask

    // decode each frame on uart_tx by sampling mid-bit
    initial begin : tx_mon
        logic [9:0] got;
        logic       ab;
        int         per;
        txe_t       e;
        forever begin
            @(negedge uart_tx);
            per = (tx_q.size() > 0) ? tx_q[0].per : mon_per;
            ab  = rstn;
            repeat (per / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                if (i > 0) repeat (per) @(negedge clk);
                got[i] = uart_tx;
                ab = ab | rstn;
            end
            if (!ab) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got frame %b expected none", got);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_frame", {22'd0, got}, {22'd0, 1'b1, e.b, 1'b0});
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] v;
        logic [7:0]  b;
        logic        s;
        int          n, p, lows;
        string       hello;

        rstn = 1'b1;
        we = 1'b0;
        addr = '0;
        wd = '0;
        uart_rx = 1'b1;
        m_txen = 0; m_rxen = 0; m_valid = 0; m_ferr = 0; m_data = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        rdr(A_CTRL, v); check("rst_ctrl", v, 32'd0);
        rdr(A_TX, v);   check("rst_txdata", v, 32'd0);
        rdr(A_BAUD, v); check("rst_baud", v, 32'd0);
        rdr(A_RX, v);   check("rst_rxdata", v, 32'd0);

        // 'H' at 512 cycles per bit
        ctrl_w(32'h3);
        set_baud(16'h200);
        rdr(A_BAUD, v); check("baud_rb", v, 32'h200);
        rdr(4'h9, v);   check("unmapped", v, 32'd0);
        tx_q.push_back('{8'h48, 512});
        wr(A_TX, 32'h48);
        #1;
        check("tx_start_edge", {31'd0, uart_tx}, 32'd0);
        rdr(A_CTRL, v);
        check("busy_set", {31'd0, v[2]}, 32'd1);
        n = 1;
        while (v[2] && n < 20000) begin
            rdr(A_CTRL, v);
            n++;
        end
        check("frame_cycles", n, 5120);

        set_baud(16);
        hello = "Hello World!\n";
        for (int i = 0; i < hello.len(); i++) send(hello[i]);

        for (int i = 0; i < 8; i++) begin
            wait_idle();
            p = $urandom_range(0, 24);
            set_baud(p);
            send(8'($urandom));
        end

        // write while busy, then tx_en dropped mid-frame
        wait_idle();
        set_baud(16);
        send(8'hAA);
        repeat (30) @(negedge clk);
        wr(A_TX, 32'h55);
        rdr(A_TX, v); check("txdata_busy_drop", v, 32'hAA);
        ctrl_w(32'h0);
        wait_idle();
        wr(A_TX, 32'h33);
        rdr(A_TX, v); check("txdata_idle_latch", v, 32'h33);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("tx_disabled_idle", lows, 0);
        rdr(A_CTRL, v); check("tx_disabled_busy", {31'd0, v[2]}, 32'd0);

`ifdef UART_RX_EN
        ctrl_w(32'h3);
        set_baud(16);
        rx_frame(8'hA5, 1'b1, 16);
        m_data = 8'hA5; m_valid = 1;
        rx_check("rx_a5");
        ctrl_w(32'h3);
        rx_check("rx_clr");
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(4, 24);
            set_baud(p);
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            rx_frame(b, s, p);
            if (s) begin
                m_data = b;
                m_valid = 1;
            end else begin
                m_ferr = 1;
            end
            rx_check("rx_rand");
            if ($urandom_range(0, 1) == 1) ctrl_w(32'h3);
            else ctrl_w(32'h1B);
        end
        set_baud(16);
        rx_frame(8'h3C, 1'b0, 16);
        m_ferr = 1;
        rx_check("rx_ferr");
        ctrl_w(32'h1);
        rx_frame(8'h77, 1'b1, 16);
        rx_check("rx_disabled");
`else
        ctrl_w(32'h1B);
        set_baud(16);
        rx_frame(8'hA5, 1'b1, 16);
        rdr(A_CTRL, v); check("norx_ctrl", v, 32'h1);
        rdr(A_RX, v);   check("norx_data", v, 32'd0);
`endif

        // reset in the middle of a frame
        ctrl_w(32'h1);
        set_baud(16);
        wait_idle();
        wr(A_TX, 32'hC3);
        repeat (40) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        rdr(A_CTRL, v); check("rst_mid_busy", {31'd0, v[2]}, 32'd0);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        rdr(A_BAUD, v); check("rst_mid_baud", v, 32'd0);
        repeat (400) @(negedge clk);
        check("tx_q_drained", tx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_top_si.md
# uart_top_si

UART peripheral with a simple register interface: one 8N1 transmitter, one 8N1 receiver and a programmable baud divider. It is controlled through a word-wide simple bus (address, write enable, write data, combinational read data) and sits on the SoC peripheral bus.

## Interface
- no parameters
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous, active-high reset (asserted = 1)
- addr  in  4  register byte address (0x0, 0x4, 0x8, 0xC; others decode to nothing)
- we  in  1  write strobe, sampled at rising clk
- wd  in  32  write data
- rd  out  32  read data, combinational from addr
- uart_tx  out  1  serial output, idle high
- uart_rx  in  1  serial input, idle high

## Operation
- Register map:
  - 0x0 CTRL: bit0 tx_en, bit1 rx_en, bit2 tx_busy (RO), bit3 rx_valid (W0C), bit4 rx_ferr (W0C); upper bits read 0.
  - 0x4 TXDATA: bits[7:0], write starts a frame.
  - 0x8 BAUD: bits[15:0], clk cycles per bit.
  - 0xC RXDATA: bits[7:0], RO.
- Unused register bits read 0. Reads of unmapped addresses return 0.
- A CTRL write updates tx_en and rx_en. Writing 0 to bit3 or bit4 clears that bit; writing 1 leaves it unchanged. tx_busy ignores writes.
- TXDATA write with tx_en=1 and tx_busy=0:
  - Latches the byte and sets tx_busy.
  - Sends start bit 0, then 8 data bits LSB first, then stop bit 1.
  - tx_busy clears when the stop bit ends.
- TXDATA write while busy or with tx_en=0 is dropped. The register still latches for readback only when idle.
- Bit period is BAUD cycles. BAUD values below 2 are treated as 2.
- Receiver, when rx_en=1:
  - A falling edge on the 2-flop synchronized uart_rx starts reception.
  - The start bit is re-checked at BAUD/2. If it is high, the receiver returns to idle.
  - Data bits are sampled mid-bit, LSB first.
  - The stop bit is sampled mid-bit. On stop=1, RXDATA is updated and rx_valid is set. On stop=0, rx_ferr is set and RXDATA is not updated.
  - A new byte overwrites RXDATA even if rx_valid is already set.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE. RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
- Clearing tx_en or rx_en mid-frame does not abort the frame in progress.

## Timing
- Reset values: all registers 0, uart_tx=1, both FSMs IDLE, rd follows registers (0).
- A write takes effect at the rising edge where we=1. Readback of the new value is available on the next cycle.
- After an accepted TXDATA write:
  - tx_busy=1 from the next cycle.
  - uart_tx goes low on the same edge that sets busy.
  - The frame lasts 10*BAUD cycles. busy drops on the final stop-bit cycle boundary.
- RX: rx_valid is set 2 sync cycles + 9.5*BAUD cycles after the start edge.
- Asserting reset mid-frame aborts immediately: uart_tx=1, FSMs return to IDLE.
- A BAUD change mid-frame takes effect on the next bit boundary.

## Configuration
- UART_RX_EN defined: receiver compiled in as described.
- UART_RX_EN undefined:
  - Receiver logic removed and uart_rx ignored.
  - CTRL bits 1, 3 and 4 and RXDATA read 0. Writes to them have no effect.

## Structure
- Shared package uart_pkg holds:
  - register address constants (UART_CTRL=4'h0, UART_TX=4'h4, UART_BAUD=4'h8, UART_RX=4'hC);
  - CTRL bit index constants;
  - the FSM state enum shared by TX and RX.
- One sub-module, uart_rx (synchronizer, mid-bit sampler, RX FSM). The transmitter, register file and read mux stay in the top.

## Test plan
- Reset -> uart_tx=1; CTRL, TXDATA, BAUD and RXDATA all read 0.
- Write CTRL=0x3, BAUD=0x200, TXDATA=0x48 ('H') -> uart_tx produces 0,0,0,0,1,0,0,1,0,1, each bit lasting 512 cycles. CTRL bit2 reads 1 during the frame and 0 after 5120 cycles.
- Send "Hello World!\n" by polling CTRL bit2 before each TXDATA write -> 13 back-to-back frames with correct bytes and no dropped characters.
- TXDATA=0x55 written while busy -> ignored, current frame unchanged. TXDATA written with tx_en=0 -> no frame, uart_tx stays 1.
- Drive uart_rx with byte 0xA5 at BAUD=16 and valid stop -> RXDATA=0xA5, rx_valid=1. Write CTRL=0x3 -> rx_valid clears.
- Drive a frame with stop bit 0 -> rx_ferr=1, RXDATA unchanged. Assert reset mid TX frame -> uart_tx=1 immediately, tx_busy=0.
